// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART receive sequencer.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    localparam int BAUD_DIV_DEF   = 5208;
    localparam int NUM_SHIFTS_DEF = 10;

    function automatic int bitcnt_w(input int num_shifts);
        return $clog2(num_shifts + 1);
    endfunction

    localparam int BITCNT_W = bitcnt_w(NUM_SHIFTS_DEF);

endpackage

// File: rtl/rx_baud_timer.sv
// Bit-time counter with clear/run control and tick decodes for half, pre-wrap and wrap counts.
module rx_baud_timer #(
    parameter int BAUD_DIV = 16,
    parameter int CNT_W    = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic half_tick,
    output logic pre_tick,
    output logic full_tick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= full_tick ? '0 : count + CNT_W'(1);
        end
    end

    assign half_tick = (count == CNT_W'(BAUD_DIV / 2 - 1));
    // One count early so a registered shift lands exactly on the wrap cycle.
    assign pre_tick  = (count == CNT_W'(BAUD_DIV - 2));
    assign full_tick = (count == CNT_W'(BAUD_DIV - 1));

endmodule

// File: rtl/rx_ctrl.sv
// UART receive sequencer: rx synchroniser, start detection, mid-bit shift pulses, frame done.
// Optional stop-bit error flag built when RX_FRAME_ERR_EN is defined.
module rx_ctrl
    import rx_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEF,
    parameter int NUM_SHIFTS = NUM_SHIFTS_DEF,
    parameter int CNT_W      = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic rx,
    output logic rx_s,
    output logic shift,
    output logic rx_done,
    output logic busy,
    output logic frame_err
);

    localparam int BW = bitcnt_w(NUM_SHIFTS);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_SHIFTS - 1);

    rx_state_t     state;
    logic [BW-1:0] bit_cnt;
    logic          sync1;
    logic          half_tick;
    logic          pre_tick;
    logic          full_tick;
    logic          timer_clear;
    logic          timer_run;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    assign timer_clear = (state == IDLE) || (state == DONE) || (state == START && half_tick);
    assign timer_run   = (state == START) || (state == DATA);

    rx_baud_timer #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (timer_clear),
        .run       (timer_run),
        .half_tick (half_tick),
        .pre_tick  (pre_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= 1'b0;
            rx_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            shift   <= 1'b0;
            rx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (enable && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (half_tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (pre_tick) shift <= 1'b1;
                    if (full_tick) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state   <= DONE;
                            rx_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_FRAME_ERR_EN
    // Sticky from the final shift until the next accepted start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (state == IDLE && enable && !rx_s) begin
            frame_err <= 1'b0;
        end else if (state == DATA && full_tick && bit_cnt == LAST_BIT && !rx_s) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
